// File: rtl/dma_ahb_multichannel.sv
// dma_ahb_multichannel: ChannelCount memory-to-memory DMA channels share one AHB-Lite
// manager port. Software programs the channels through a zero-wait AHB-Lite subordinate
// register port, and a round-robin arbiter picks a channel for each beat.
// Optional feature macro: DMA_ERROR_ABORT_EN. When it is defined, M_HRESP=ERROR aborts
// the channel and sets CTRL.ERR.
// Handshake: a phase (address or data) advances only on a rising HCLK edge with HREADY high.
// Until then the manager holds HADDR/HTRANS/HWRITE/HSIZE/HWDATA stable.
// dbg_state exposes the manager FSM state (0 IDLE, 1 RD_A, 2 RD_D, 3 WR_A, 4 WR_D).
module dma_ahb_multichannel #(
    parameter int ChannelCount = 4,
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int LengthWidth  = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    S_HSEL,
    input  logic [AddressWidth-1:0] S_HADDR,
    input  logic [1:0]              S_HTRANS,
    input  logic                    S_HWRITE,
    input  logic [2:0]              S_HSIZE,
    input  logic [DataWidth-1:0]    S_HWDATA,
    input  logic                    S_HREADY,
    output logic [DataWidth-1:0]    S_HRDATA,
    output logic                    S_HREADYOUT,
    output logic                    S_HRESP,
    output logic [AddressWidth-1:0] M_HADDR,
    output logic [1:0]              M_HTRANS,
    output logic                    M_HWRITE,
    output logic [2:0]              M_HSIZE,
    output logic [2:0]              M_HBURST,
    output logic [DataWidth-1:0]    M_HWDATA,
    input  logic [DataWidth-1:0]    M_HRDATA,
    input  logic                    M_HREADY,
    input  logic                    M_HRESP,
    output logic [ChannelCount-1:0] IRQ,
    output logic [2:0]              dbg_state
);
    localparam int ChW     = (ChannelCount > 1) ? $clog2(ChannelCount) : 1;
    localparam int IdxW    = AddressWidth - 4;
    localparam int MaxSize = $clog2(DataWidth / 8);

    typedef enum logic [2:0] {ST_IDLE, ST_RD_A, ST_RD_D, ST_WR_A, ST_WR_D} state_t;

    state_t                  state;
    logic [ChW-1:0]          cur_ch, rr_ptr, grant, next_ptr;
    logic                    grant_valid;
    logic [DataWidth-1:0]    rd_data;
    logic [AddressWidth-1:0] src [ChannelCount];
    logic [AddressWidth-1:0] dst [ChannelCount];
    logic [LengthWidth-1:0]  len [ChannelCount];
    logic [2:0]              size [ChannelCount];
    logic [ChannelCount-1:0] en, ie, done, err, busy, ch_sel;
    logic                    s_wr_q, s_rd_q;
    logic [AddressWidth-1:0] s_addr_q;
    logic                    rd_abort, wr_abort, beat_abort, beat_done, unused_hresp;
    logic                    unused_sig;

    // Sizes wider than the data bus are clamped to a full-bus beat.
    function automatic logic [2:0] eff_size(input logic [2:0] s);
        return (s > 3'(MaxSize)) ? 3'(MaxSize) : s;
    endfunction

    function automatic logic [AddressWidth-1:0] step_of(input logic [2:0] s);
        return AddressWidth'(1) << eff_size(s);
    endfunction

`ifdef DMA_ERROR_ABORT_EN
    assign rd_abort     = (state == ST_RD_D) && M_HREADY && M_HRESP;
    assign wr_abort     = (state == ST_WR_D) && M_HREADY && M_HRESP;
    assign unused_hresp = 1'b0;
    assign IRQ          = (done & ie) | (err & ie);
`else
    assign rd_abort     = 1'b0;
    assign wr_abort     = 1'b0;
    assign unused_hresp = M_HRESP;
    assign IRQ          = done & ie;
`endif
    assign beat_abort  = rd_abort | wr_abort;
    assign beat_done   = (state == ST_WR_D) && M_HREADY && !wr_abort;
    assign S_HREADYOUT = 1'b1;
    assign S_HRESP     = 1'b0;
    assign M_HBURST    = 3'b000;
    assign dbg_state   = state;
    assign unused_sig  = ^{S_HSIZE, S_HTRANS[0], S_HWDATA, s_addr_q[1:0], unused_hresp};

    // Channel decode of the registered subordinate address, plus per-channel busy flags.
    always_comb begin
        ch_sel = '0;
        busy   = '0;
        for (int n = 0; n < ChannelCount; n++) begin
            ch_sel[n] = (s_addr_q[AddressWidth-1:4] == IdxW'(n));
            busy[n]   = en[n] | ((state != ST_IDLE) && (cur_ch == ChW'(n)));
        end
    end

    // Register read data during the data phase; unmapped addresses read 0.
    always_comb begin
        S_HRDATA = '0;
        for (int n = 0; n < ChannelCount; n++) begin
            if (s_rd_q && ch_sel[n]) begin
                case (s_addr_q[3:2])
                    2'd0:    S_HRDATA = DataWidth'(src[n]);
                    2'd1:    S_HRDATA = DataWidth'(dst[n]);
                    2'd2:    S_HRDATA = DataWidth'(len[n]);
                    default: S_HRDATA = DataWidth'({err[n], done[n], ie[n], size[n], busy[n]});
                endcase
            end
        end
    end

    // Round-robin grant: search starts at rr_ptr, the channel after the last one served.
    always_comb begin
        int k;
        k           = 0;
        grant_valid = 1'b0;
        grant       = '0;
        next_ptr    = '0;
        for (int i = 0; i < ChannelCount; i++) begin
            k = (int'(rr_ptr) + i) % ChannelCount;
            if (!grant_valid && en[k]) begin
                grant_valid = 1'b1;
                grant       = ChW'(k);
                next_ptr    = ChW'((k + 1) % ChannelCount);
            end
        end
    end

    // Subordinate address phase register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s_wr_q   <= 1'b0;
            s_rd_q   <= 1'b0;
            s_addr_q <= '0;
        end else begin
            s_wr_q <= S_HSEL && S_HREADY && S_HTRANS[1] && S_HWRITE;
            s_rd_q <= S_HSEL && S_HREADY && S_HTRANS[1] && !S_HWRITE;
            if (S_HSEL && S_HREADY && S_HTRANS[1]) s_addr_q <= S_HADDR;
        end
    end

    // Channel registers. Software writes come first, so hardware updates win on a collision.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            en   <= '0;
            ie   <= '0;
            done <= '0;
            err  <= '0;
            for (int n = 0; n < ChannelCount; n++) begin
                src[n]  <= '0;
                dst[n]  <= '0;
                len[n]  <= '0;
                size[n] <= '0;
            end
        end else begin
            for (int n = 0; n < ChannelCount; n++) begin
                if (s_wr_q && ch_sel[n]) begin
                    case (s_addr_q[3:2])
                        2'd0: if (!busy[n]) src[n] <= AddressWidth'(S_HWDATA);
                        2'd1: if (!busy[n]) dst[n] <= AddressWidth'(S_HWDATA);
                        2'd2: if (!busy[n]) len[n] <= LengthWidth'(S_HWDATA);
                        default: begin
                            ie[n] <= S_HWDATA[4];
                            if (S_HWDATA[5]) done[n] <= 1'b0;
                            if (S_HWDATA[6]) err[n]  <= 1'b0;
                            if (busy[n]) begin
                                en[n] <= en[n] & S_HWDATA[0];
                            end else begin
                                size[n] <= S_HWDATA[3:1];
                                if (S_HWDATA[0]) begin
                                    if (len[n] == '0) done[n] <= 1'b1;
                                    else              en[n]   <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
                if (beat_done && (cur_ch == ChW'(n))) begin
                    src[n] <= src[n] + step_of(size[n]);
                    dst[n] <= dst[n] + step_of(size[n]);
                    len[n] <= len[n] - LengthWidth'(1);
                    if (len[n] == LengthWidth'(1)) begin
                        en[n] <= 1'b0;
                        if (en[n]) done[n] <= 1'b1;
                    end
                end
`ifdef DMA_ERROR_ABORT_EN
                if (beat_abort && (cur_ch == ChW'(n))) begin
                    en[n]  <= 1'b0;
                    err[n] <= 1'b1;
                end
`endif
            end
        end
    end

    // Manager FSM: one read then one write per beat, all bus outputs registered.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            cur_ch   <= '0;
            rr_ptr   <= '0;
            rd_data  <= '0;
            M_HADDR  <= '0;
            M_HTRANS <= 2'b00;
            M_HWRITE <= 1'b0;
            M_HSIZE  <= 3'b000;
            M_HWDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: if (grant_valid) begin
                    cur_ch   <= grant;
                    rr_ptr   <= next_ptr;
                    M_HADDR  <= src[grant];
                    M_HTRANS <= 2'b10;
                    M_HWRITE <= 1'b0;
                    M_HSIZE  <= eff_size(size[grant]);
                    state    <= ST_RD_A;
                end
                ST_RD_A: if (M_HREADY) begin
                    M_HTRANS <= 2'b00;
                    state    <= ST_RD_D;
                end
                ST_RD_D: if (beat_abort) begin
                    state <= ST_IDLE;
                end else if (M_HREADY) begin
                    rd_data  <= M_HRDATA;
                    M_HADDR  <= dst[cur_ch];
                    M_HTRANS <= 2'b10;
                    M_HWRITE <= 1'b1;
                    state    <= ST_WR_A;
                end
                ST_WR_A: if (M_HREADY) begin
                    M_HWDATA <= rd_data;
                    M_HTRANS <= 2'b00;
                    state    <= ST_WR_D;
                end
                ST_WR_D: if (M_HREADY) begin
                    M_HWRITE <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_ahb_multichannel.sv
// Directed testbench for dma_ahb_multichannel. A small AHB memory model answers the
// manager port, returning address ^ PAT as read data. It logs every completed read
// and write data phase, and the tests check those logs against hand-computed values.
module tb_dma_ahb_multichannel;
    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        S_HSEL, S_HWRITE, S_HREADY;
    logic [31:0] S_HADDR, S_HWDATA;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HRDATA;
    logic        S_HREADYOUT, S_HRESP;
    logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE, M_HREADY, M_HRESP;
    logic [2:0]  M_HSIZE, M_HBURST;
    logic [3:0]  IRQ;
    logic [2:0]  dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Bus model state and logs.
    logic        d_valid = 1'b0, d_write = 1'b0;
    logic [31:0] d_addr = '0, rd_addr = '0;
    int          aph_cnt = 0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] exp_q[$];

    dma_ahb_multichannel #(
        .ChannelCount(4), .AddressWidth(32), .DataWidth(32), .LengthWidth(16)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
        .M_HBURST(M_HBURST), .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA),
        .M_HREADY(M_HREADY), .M_HRESP(M_HRESP), .IRQ(IRQ), .dbg_state(dbg_state)
    );

    // Clock.
    always #5 HCLK = ~HCLK;

    assign M_HRDATA = rd_addr ^ PAT;

    // Memory model: on the falling edge, look at the phases that complete at the next rising edge.
    always @(negedge HCLK) begin
        if (HRESET) begin
            d_valid = 1'b0;
        end else if (M_HREADY) begin
            if (d_valid) begin
                if (d_write) begin
                    wr_addr_log.push_back(d_addr);
                    wr_data_log.push_back(M_HWDATA);
                end else begin
                    rd_log.push_back(d_addr);
                end
            end
            if (M_HTRANS[1]) begin
                d_valid = 1'b1;
                d_addr  = M_HADDR;
                d_write = M_HWRITE;
                aph_cnt++;
                if (!M_HWRITE) rd_addr = M_HADDR;
            end else begin
                d_valid = 1'b0;
            end
        end
    end

    // Driver tasks: each starts and ends 1 time unit after a rising edge.
    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HWRITE = 1'b1; S_HADDR = addr;
        @(posedge HCLK); #1;
        S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWRITE = 1'b0; S_HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HWRITE = 1'b0; S_HADDR = addr;
        @(posedge HCLK); #1;
        S_HSEL = 1'b0; S_HTRANS = 2'b00;
        data = S_HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic program_ch(input int ch, input logic [31:0] s, input logic [31:0] d,
                              input logic [31:0] l);
        reg_write(32'(ch * 16 + 0), s);
        reg_write(32'(ch * 16 + 4), d);
        reg_write(32'(ch * 16 + 8), l);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        exp_q.delete();
    endtask

    // Polls CTRL until the busy bit drops; an expired budget counts as a miscompare.
    task automatic wait_idle(input int ch);
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            reg_read(32'(ch * 16 + 12), v);
            n++;
        end while (v[0] && n < 200);
        vec_cnt++;
        if (v[0]) begin
            err_cnt++;
            $display("FAIL wait_idle ch%0d: still busy after %0d polls, required idle", ch, n);
        end
    endtask

    task automatic wait_state(input logic [2:0] st);
        int n;
        n = 0;
        while (dbg_state !== st && n < 50) begin
            @(posedge HCLK); #1;
            n++;
        end
        vec_cnt++;
        if (dbg_state !== st) begin
            err_cnt++;
            $display("FAIL wait_state: state %0d, required %0d", dbg_state, st);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        vec_cnt++; if (M_HTRANS !== 2'b00) begin err_cnt++; $display("FAIL rst_htrans: got %h required 0", M_HTRANS); end
        vec_cnt++; if (M_HADDR !== 32'h0) begin err_cnt++; $display("FAIL rst_haddr: got %h required 0", M_HADDR); end
        vec_cnt++; if (IRQ !== 4'h0) begin err_cnt++; $display("FAIL rst_irq: got %h required 0", IRQ); end
        vec_cnt++; if (S_HRDATA !== 32'h0) begin err_cnt++; $display("FAIL rst_hrdata: got %h required 0", S_HRDATA); end
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        vec_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
        vec_cnt++; if (S_HREADYOUT !== 1'b1 || S_HRESP !== 1'b0) begin err_cnt++; $display("FAIL rst_sresp: got %b%b required 10", S_HREADYOUT, S_HRESP); end
        reg_read(32'h0000_0000, v);
        vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL rst_src0: got %h required 0", v); end
        reg_read(32'h0000_000C, v);
        vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL rst_ctrl0: got %h required 0", v); end
        reg_write(32'h0000_0040, 32'hFFFF_FFFF);
        reg_read(32'h0000_0040, v);
        vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL unmapped_rd: got %h required 0", v); end
    endtask

    task automatic test_single_channel();
        logic [31:0] v;
        clear_logs();
        program_ch(0, 32'h1000, 32'h2000, 32'd4);
        reg_write(32'h0C, 32'h15);
        wait_idle(0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(32'h1000 + 4 * i) ^ PAT);
        vec_cnt++; if (wr_data_log.size() != 4 || rd_log.size() != 4) begin err_cnt++; $display("FAIL basic_count: got rd %0d wr %0d required 4 4", rd_log.size(), wr_data_log.size()); end
        for (int i = 0; i < 4; i++) begin
            vec_cnt++; if (rd_log[i] !== 32'(32'h1000 + 4 * i)) begin err_cnt++; $display("FAIL basic_rd_addr%0d: got %h required %h", i, rd_log[i], 32'h1000 + 4 * i); end
            vec_cnt++; if (wr_addr_log[i] !== 32'(32'h2000 + 4 * i)) begin err_cnt++; $display("FAIL basic_wr_addr%0d: got %h required %h", i, wr_addr_log[i], 32'h2000 + 4 * i); end
            vec_cnt++; if (wr_data_log[i] !== exp_q[i]) begin err_cnt++; $display("FAIL basic_wr_data%0d: got %h required %h", i, wr_data_log[i], exp_q[i]); end
        end
        reg_read(32'h08, v);
        vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL basic_len: got %h required 0", v); end
        reg_read(32'h00, v);
        vec_cnt++; if (v !== 32'h1010) begin err_cnt++; $display("FAIL basic_src: got %h required 1010", v); end
        reg_read(32'h0C, v);
        vec_cnt++; if (v !== 32'h34) begin err_cnt++; $display("FAIL basic_ctrl: got %h required 34", v); end
        vec_cnt++; if (IRQ !== 4'b0001) begin err_cnt++; $display("FAIL basic_irq: got %b required 0001", IRQ); end
        reg_write(32'h0C, 32'h30);
        vec_cnt++; if (IRQ !== 4'b0000) begin err_cnt++; $display("FAIL basic_w1c: got %b required 0000", IRQ); end
    endtask

    task automatic test_interleave();
        logic [31:0] v;
        logic [31:0] exp_rd[4];
        exp_rd[0] = 32'h3000; exp_rd[1] = 32'h5000; exp_rd[2] = 32'h3004; exp_rd[3] = 32'h5004;
        clear_logs();
        program_ch(0, 32'h3000, 32'h4000, 32'd2);
        program_ch(2, 32'h5000, 32'h6000, 32'd2);
        reg_write(32'h0C, 32'h05);
        reg_write(32'h2C, 32'h05);
        wait_idle(0);
        wait_idle(2);
        vec_cnt++; if (rd_log.size() != 4) begin err_cnt++; $display("FAIL ilv_count: got %0d required 4", rd_log.size()); end
        for (int i = 0; i < 4; i++) begin
            vec_cnt++; if (rd_log[i] !== exp_rd[i]) begin err_cnt++; $display("FAIL ilv_order%0d: got %h required %h", i, rd_log[i], exp_rd[i]); end
        end
        reg_read(32'h0C, v);
        vec_cnt++; if (v !== 32'h24) begin err_cnt++; $display("FAIL ilv_ctrl0: got %h required 24", v); end
        reg_read(32'h2C, v);
        vec_cnt++; if (v !== 32'h24) begin err_cnt++; $display("FAIL ilv_ctrl2: got %h required 24", v); end
        vec_cnt++; if (IRQ !== 4'b0000) begin err_cnt++; $display("FAIL ilv_irq_masked: got %b required 0000", IRQ); end
        reg_write(32'h0C, 32'h20);
        reg_write(32'h2C, 32'h20);
    endtask

    task automatic test_wait_states();
        clear_logs();
        program_ch(1, 32'h7000, 32'h7100, 32'd1);
        reg_write(32'h1C, 32'h05);
        wait_state(3'd2);
        M_HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge HCLK); #1;
            vec_cnt++; if (dbg_state !== 3'd2 || M_HADDR !== 32'h7000 || M_HTRANS !== 2'b00) begin err_cnt++; $display("FAIL stall_hold%0d: got st %0d addr %h trans %b required 2 7000 00", i, dbg_state, M_HADDR, M_HTRANS); end
        end
        M_HREADY = 1'b1;
        @(posedge HCLK); #1;
        vec_cnt++; if (dbg_state !== 3'd3 || M_HADDR !== 32'h7100 || M_HTRANS !== 2'b10) begin err_cnt++; $display("FAIL stall_release: got st %0d addr %h trans %b required 3 7100 10", dbg_state, M_HADDR, M_HTRANS); end
        wait_idle(1);
        vec_cnt++; if (wr_data_log.size() != 1 || wr_data_log[0] !== 32'hA5A5_7000) begin err_cnt++; $display("FAIL stall_data: got %h required a5a57000", wr_data_log[0]); end
    endtask

    task automatic test_len_zero();
        logic [31:0] v;
        int aph0;
        reg_write(32'h38, 32'd0);
        aph0 = aph_cnt;
        reg_write(32'h3C, 32'h11);
        vec_cnt++; if (IRQ !== 4'b1000) begin err_cnt++; $display("FAIL len0_irq: got %b required 1000", IRQ); end
        reg_read(32'h3C, v);
        vec_cnt++; if (v !== 32'h30) begin err_cnt++; $display("FAIL len0_ctrl: got %h required 30", v); end
        vec_cnt++; if (aph_cnt != aph0) begin err_cnt++; $display("FAIL len0_traffic: got %0d address phases required 0", aph_cnt - aph0); end
        reg_write(32'h3C, 32'h30);
        vec_cnt++; if (IRQ !== 4'b0000) begin err_cnt++; $display("FAIL len0_w1c: got %b required 0000", IRQ); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        clear_logs();
        program_ch(1, 32'hFFFF_FFFC, 32'h8000, 32'd2);
        reg_write(32'h1C, 32'h05);
        wait_idle(1);
        vec_cnt++; if (rd_log.size() != 2 || rd_log[0] !== 32'hFFFF_FFFC || rd_log[1] !== 32'h0) begin err_cnt++; $display("FAIL wrap_rd: got %h %h required fffffffc 00000000", rd_log[0], rd_log[1]); end
        vec_cnt++; if (wr_data_log.size() != 2 || wr_data_log[1] !== 32'hA5A5_0000) begin err_cnt++; $display("FAIL wrap_wr: got %h required a5a50000", wr_data_log[1]); end
        reg_read(32'h10, v);
        vec_cnt++; if (v !== 32'h4) begin err_cnt++; $display("FAIL wrap_src: got %h required 4", v); end
    endtask

    task automatic test_error();
        logic [31:0] v;
        int seen;
        bit hit;
        clear_logs();
        seen = 0;
        hit  = 1'b0;
        program_ch(0, 32'h9000, 32'hA000, 32'd4);
        reg_write(32'h0C, 32'h15);
        for (int n = 0; n < 60 && !hit; n++) begin
            if (dbg_state === 3'd2) begin
                seen++;
                if (seen == 2) begin
                    M_HRESP = 1'b1;
                    @(posedge HCLK); #1;
                    M_HRESP = 1'b0;
                    hit = 1'b1;
                end
            end
            if (!hit) begin
                @(posedge HCLK); #1;
            end
        end
        vec_cnt++; if (!hit) begin err_cnt++; $display("FAIL err_inject: saw %0d read data phases, required 2", seen); end
        wait_idle(0);
        reg_read(32'h08, v);
`ifdef DMA_ERROR_ABORT_EN
        vec_cnt++; if (v !== 32'd3) begin err_cnt++; $display("FAIL err_len: got %h required 3", v); end
        reg_read(32'h00, v);
        vec_cnt++; if (v !== 32'h9004) begin err_cnt++; $display("FAIL err_src: got %h required 9004", v); end
        reg_read(32'h0C, v);
        vec_cnt++; if (v !== 32'h54) begin err_cnt++; $display("FAIL err_ctrl: got %h required 54", v); end
`else
        vec_cnt++; if (v !== 32'd0) begin err_cnt++; $display("FAIL err_len: got %h required 0", v); end
        reg_read(32'h00, v);
        vec_cnt++; if (v !== 32'h9010) begin err_cnt++; $display("FAIL err_src: got %h required 9010", v); end
        reg_read(32'h0C, v);
        vec_cnt++; if (v !== 32'h34) begin err_cnt++; $display("FAIL err_ctrl: got %h required 34", v); end
`endif
        vec_cnt++; if (IRQ !== 4'b0001) begin err_cnt++; $display("FAIL err_irq: got %b required 0001", IRQ); end
        reg_write(32'h0C, 32'h60);
        vec_cnt++; if (IRQ !== 4'b0000) begin err_cnt++; $display("FAIL err_clear: got %b required 0000", IRQ); end
    endtask

    task automatic test_en_clear();
        logic [31:0] v;
        clear_logs();
        program_ch(2, 32'hB000, 32'hC000, 32'd3);
        reg_write(32'h2C, 32'h0F);
        wait_state(3'd1);
        vec_cnt++; if (M_HSIZE !== 3'd2 || M_HADDR !== 32'hB000) begin err_cnt++; $display("FAIL clamp_size: got size %0d addr %h required 2 b000", M_HSIZE, M_HADDR); end
        reg_write(32'h2C, 32'h0E);
        wait_idle(2);
        reg_read(32'h28, v);
        vec_cnt++; if (v !== 32'd2) begin err_cnt++; $display("FAIL stop_len: got %h required 2", v); end
        reg_read(32'h24, v);
        vec_cnt++; if (v !== 32'hC004) begin err_cnt++; $display("FAIL stop_dst: got %h required c004", v); end
        reg_read(32'h2C, v);
        vec_cnt++; if (v !== 32'h0E) begin err_cnt++; $display("FAIL stop_ctrl: got %h required 0e", v); end
        vec_cnt++; if (wr_data_log.size() != 1) begin err_cnt++; $display("FAIL stop_beats: got %0d required 1", wr_data_log.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int aph0;
        program_ch(1, 32'hD000, 32'hE000, 32'd4);
        reg_write(32'h1C, 32'h05);
        wait_state(3'd2);
        HRESET = 1'b1;
        #1;
        vec_cnt++; if (M_HTRANS !== 2'b00 || M_HADDR !== 32'h0 || dbg_state !== 3'd0) begin err_cnt++; $display("FAIL rstmid_out: got trans %b addr %h st %0d required 00 0 0", M_HTRANS, M_HADDR, dbg_state); end
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        aph0 = aph_cnt;
        repeat (10) @(posedge HCLK);
        #1;
        vec_cnt++; if (aph_cnt != aph0) begin err_cnt++; $display("FAIL rstmid_traffic: got %0d address phases required 0", aph_cnt - aph0); end
        reg_read(32'h18, v);
        vec_cnt++; if (v !== 32'h0) begin err_cnt++; $display("FAIL rstmid_len: got %h required 0", v); end
    endtask

    initial begin
        S_HSEL = 1'b0; S_HADDR = '0; S_HTRANS = 2'b00; S_HWRITE = 1'b0;
        S_HSIZE = 3'd2; S_HWDATA = '0; S_HREADY = 1'b1;
        M_HREADY = 1'b1; M_HRESP = 1'b0;
        test_reset();
        test_single_channel();
        test_interleave();
        test_wait_states();
        test_len_zero();
        test_wrap();
        test_error();
        test_en_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
